// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared size codes, FSM state and owner encodings for ram_port_arbiter
package ram_arb_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: fetch port, data port and RAM pin bundle shared by the arbiter and its neighbours
//   I_*   : instruction-fetch requester (word reads)
//   D_*   : data requester (byte/half/word, read/write, error flag)
//   Ram*  : pins of the data_ram256x8 instance
//   slave : arbiter view; master : pipeline + RAM view
interface ram_port_arbiter_if;
  logic        I_Req;
  logic [31:0] I_Address;
  logic        I_Ready;
  logic [31:0] I_DataOut;
  logic        D_Req;
  logic        D_ReadWrite;
  logic [1:0]  D_Size;
  logic [31:0] D_Address;
  logic [31:0] D_DataIn;
  logic        D_Ready;
  logic [31:0] D_DataOut;
  logic        D_Err;
  logic        RamReadWrite;
  logic [31:0] RamAddress;
  logic [31:0] RamDataIn;
  logic [1:0]  RamSize;
  logic [31:0] RamDataOut;
  modport slave (
    input  I_Req, I_Address, D_Req, D_ReadWrite, D_Size, D_Address, D_DataIn, RamDataOut,
    output I_Ready, I_DataOut, D_Ready, D_DataOut, D_Err, RamReadWrite, RamAddress, RamDataIn, RamSize
  );
  modport master (
    output I_Req, I_Address, D_Req, D_ReadWrite, D_Size, D_Address, D_DataIn, RamDataOut,
    input  I_Ready, I_DataOut, D_Ready, D_DataOut, D_Err, RamReadWrite, RamAddress, RamDataIn, RamSize
  );
endinterface

// File: rtl/ram_arb_align_chk.sv
// ram_arb_align_chk: flags data accesses that are misaligned, reserved-size or beyond the RAM
//   size, addr : requested D access
//   err        : access must be rejected
module ram_arb_align_chk
  import ram_arb_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  output logic        err
);
  assign err = size == SIZE_RSVD
            || (size == SIZE_HALF && addr[0])
            || (size == SIZE_WORD && addr[1:0] != 2'b00)
            || (addr >> ADDR_BITS) != 32'd0;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one byte RAM between the fetch port (I) and the data port (D)
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : ram_port_arbiter_if.slave carrying the I, D and RAM pins
// Each access runs IDLE -> ACCESS -> RESP; D has priority but I is forced in after
// MAX_D_STREAK consecutive D grants taken while I was waiting.
// Define ARB_ALIGN_CHECK_EN to reject misaligned / reserved / out-of-range D accesses.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  ram_port_arbiter_if.slave   bus
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);
  state_t        state, state_n;
  owner_t        owner;
  logic [SW-1:0] streak;
  logic          any_req, d_win, rej, rej_q;
`ifdef ARB_ALIGN_CHECK_EN
  ram_arb_align_chk #(.ADDR_BITS(ADDR_BITS)) u_chk (
    .size (bus.D_Size),
    .addr (bus.D_Address),
    .err  (rej)
  );
`else
  assign rej = 1'b0;
`endif
  assign any_req = bus.I_Req || bus.D_Req;
  assign d_win   = bus.D_Req && !(bus.I_Req && streak == SMAX);
  always_comb begin
    state_n = state == IDLE   ? (any_req ? ACCESS : IDLE)
            : state == ACCESS ? RESP
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      owner            <= OWN_I;
      streak           <= '0;
      rej_q            <= 1'b0;
      bus.I_Ready      <= 1'b0;
      bus.I_DataOut    <= '0;
      bus.D_Ready      <= 1'b0;
      bus.D_DataOut    <= '0;
      bus.D_Err        <= 1'b0;
      bus.RamReadWrite <= 1'b0;
      bus.RamAddress   <= '0;
      bus.RamDataIn    <= '0;
      bus.RamSize      <= '0;
    end else begin
      state       <= state_n;
      bus.I_Ready <= state == ACCESS && owner == OWN_I;
      bus.D_Ready <= state == ACCESS && owner == OWN_D;
      bus.D_Err   <= state == ACCESS && owner == OWN_D && rej_q;
      if (state == IDLE && any_req) begin
        owner            <= d_win ? OWN_D : OWN_I;
        rej_q            <= d_win && rej;
        bus.RamReadWrite <= d_win && bus.D_ReadWrite && !rej;
        bus.RamAddress   <= d_win ? bus.D_Address : bus.I_Address;
        bus.RamDataIn    <= d_win ? bus.D_DataIn : '0;
        bus.RamSize      <= (!d_win || bus.D_Size == SIZE_RSVD) ? SIZE_WORD : bus.D_Size;
        // a D grant with I waiting can only happen while streak < SMAX, so no saturation test is needed
        streak           <= (d_win && bus.I_Req) ? streak + SW'(1) : '0;
      end else begin
        bus.RamReadWrite <= 1'b0;
      end
      if (state == ACCESS) begin
        if (owner == OWN_I) bus.I_DataOut <= bus.RamDataOut;
        else bus.D_DataOut <= (bus.RamReadWrite || rej_q) ? '0 : bus.RamDataOut;
      end
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: table-driven and scoreboard bench for ram_port_arbiter with a big-endian RAM model
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;
`ifdef ARB_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef struct {
    logic        is_d;
    logic        rw;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;
  typedef struct {
    logic        is_d;
    logic [31:0] data;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  ram_port_arbiter_if bus();
  ram_port_arbiter #(.ADDR_BITS(8), .MAX_D_STREAK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  logic [7:0] mem [256];
  logic [7:0] sh  [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_a, pre_d, ra;
  assign ra = bus.RamAddress[7:0];
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (bus.RamReadWrite) begin
      if (bus.RamSize == 2'b00) mem[ra] <= bus.RamDataIn[7:0];
      else if (bus.RamSize == 2'b01) begin
        mem[ra] <= bus.RamDataIn[15:8];
        mem[8'(ra + 8'd1)] <= bus.RamDataIn[7:0];
      end else begin
        mem[ra] <= bus.RamDataIn[31:24];
        mem[8'(ra + 8'd1)] <= bus.RamDataIn[23:16];
        mem[8'(ra + 8'd2)] <= bus.RamDataIn[15:8];
        mem[8'(ra + 8'd3)] <= bus.RamDataIn[7:0];
      end
    end
  end
  assign bus.RamDataOut = bus.RamSize == 2'b00 ? {24'd0, mem[ra]}
                        : bus.RamSize == 2'b01 ? {16'd0, mem[ra], mem[8'(ra + 8'd1)]}
                        : {mem[ra], mem[8'(ra + 8'd1)], mem[8'(ra + 8'd2)], mem[8'(ra + 8'd3)]};
  int   total = 0;
  int   passed = 0;
  int   rw_cnt = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tv[18];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h, want %h", n, act, want);
  endtask
  function automatic logic [31:0] rd(input logic [7:0] a, input logic [1:0] s);
    return s == 2'b00 ? {24'd0, sh[a]}
         : s == 2'b01 ? {16'd0, sh[a], sh[8'(a + 1)]}
         : {sh[a], sh[8'(a + 1)], sh[8'(a + 2)], sh[8'(a + 3)]};
  endfunction
  task automatic wr(input logic [7:0] a, input logic [1:0] s, input logic [31:0] d);
    if (s == 2'b00) sh[a] = d[7:0];
    else if (s == 2'b01) begin
      sh[a] = d[15:8];
      sh[8'(a + 1)] = d[7:0];
    end else begin
      sh[a] = d[31:24];
      sh[8'(a + 1)] = d[23:16];
      sh[8'(a + 2)] = d[15:8];
      sh[8'(a + 3)] = d[7:0];
    end
  endtask
  function automatic logic bad(input logic [1:0] s, input logic [31:0] a);
    return CHK && (s == 2'b11 || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00) || a > 32'hFF);
  endfunction
  always @(negedge clk) if (bus.RamReadWrite) rw_cnt++;
  always @(negedge clk) begin
    if (bus.I_Ready || bus.D_Ready) begin
      chk("single_ready", {31'd0, bus.I_Ready && bus.D_Ready}, 32'd0);
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_ready: got I_Ready=%0b D_Ready=%0b, want no response", bus.I_Ready, bus.D_Ready);
      end else begin
        mon_e = sb.pop_front();
        chk("owner_is_d", {31'd0, bus.D_Ready}, {31'd0, mon_e.is_d});
        if (mon_e.is_d) begin
          chk("d_data", bus.D_DataOut, mon_e.data);
          chk("d_err", {31'd0, bus.D_Err}, {31'd0, mon_e.err});
        end else chk("i_data", bus.I_DataOut, mon_e.data);
      end
    end
  end
  task automatic issue(input vec_t t);
    exp_t e;
    int   n;
    logic err, got;
    logic [1:0] s;
    @(posedge clk); #1;
    s = t.size == 2'b11 ? 2'b10 : t.size;
    err = t.is_d && bad(t.size, t.addr);
    e.is_d = t.is_d;
    e.err = err;
    e.data = !t.is_d ? rd(t.addr[7:0], 2'b10) : (err || t.rw) ? 32'd0 : rd(t.addr[7:0], s);
    if (t.is_d && t.rw && !err) wr(t.addr[7:0], s, t.data);
    sb.push_back(e);
    rw_cnt = 0;
    if (t.is_d) begin
      bus.D_Req = 1'b1;
      bus.D_ReadWrite = t.rw;
      bus.D_Size = t.size;
      bus.D_Address = t.addr;
      bus.D_DataIn = t.data;
    end else begin
      bus.I_Req = 1'b1;
      bus.I_Address = t.addr;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      got = t.is_d ? bus.D_Ready : bus.I_Ready;
    end while (!got && n < 8);
    if (!got) begin
      total++;
      $display("FAIL ready_timeout: got no Ready in %0d cycles, want Ready at cycle 3 (addr %h)", n, t.addr);
    end else chk("latency", n, 32'd3);
    chk("ram_write_cycles", rw_cnt, {31'd0, t.is_d && t.rw && !err});
    bus.D_Req = 1'b0;
    bus.I_Req = 1'b0;
  endtask
  initial begin
    int grants, i_at, n;
    exp_t e;
    tv[0]  = '{1'b0, 1'b0, 2'b10, 32'h00, 32'h0};
    tv[1]  = '{1'b0, 1'b0, 2'b10, 32'h04, 32'h0};
    tv[2]  = '{1'b0, 1'b0, 2'b10, 32'h08, 32'h0};
    tv[3]  = '{1'b0, 1'b0, 2'b10, 32'h0C, 32'h0};
    tv[4]  = '{1'b1, 1'b1, 2'b00, 32'h00, 32'h000000B5};
    tv[5]  = '{1'b1, 1'b0, 2'b10, 32'h00, 32'h0};
    tv[6]  = '{1'b1, 1'b1, 2'b01, 32'h20, 32'h1234ABCD};
    tv[7]  = '{1'b1, 1'b0, 2'b01, 32'h20, 32'h0};
    tv[8]  = '{1'b1, 1'b0, 2'b00, 32'h21, 32'h0};
    tv[9]  = '{1'b1, 1'b1, 2'b10, 32'h30, 32'hDEADBEEF};
    tv[10] = '{1'b1, 1'b0, 2'b10, 32'h30, 32'h0};
    tv[11] = '{1'b1, 1'b0, 2'b00, 32'h33, 32'h0};
    tv[12] = '{1'b1, 1'b1, 2'b11, 32'h40, 32'h01020304};
    tv[13] = '{1'b1, 1'b0, 2'b10, 32'h40, 32'h0};
    tv[14] = '{1'b1, 1'b1, 2'b10, 32'h06, 32'hA5A5A5A5};
    tv[15] = '{1'b1, 1'b0, 2'b01, 32'h100, 32'h0};
    tv[16] = '{1'b1, 1'b0, 2'b10, 32'h04, 32'h0};
    tv[17] = '{1'b0, 1'b0, 2'b10, 32'h04, 32'h0};
    bus.I_Req = 1'b0;
    bus.I_Address = '0;
    bus.D_Req = 1'b0;
    bus.D_ReadWrite = 1'b0;
    bus.D_Size = '0;
    bus.D_Address = '0;
    bus.D_DataIn = '0;
    for (int i = 0; i < 256; i++) begin
      pre_a = 8'(i);
      pre_d = i < 4 ? 8'(8'h11 * (i + 1)) : 8'(i * 7 + 3);
      sh[i] = pre_d;
      pre_we = 1'b1;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    @(negedge clk);
    chk("rst_i_ready", {31'd0, bus.I_Ready}, 32'd0);
    chk("rst_i_data", bus.I_DataOut, 32'd0);
    chk("rst_d_ready", {31'd0, bus.D_Ready}, 32'd0);
    chk("rst_d_data", bus.D_DataOut, 32'd0);
    chk("rst_d_err", {31'd0, bus.D_Err}, 32'd0);
    chk("rst_ram_rw", {31'd0, bus.RamReadWrite}, 32'd0);
    chk("rst_ram_addr", bus.RamAddress, 32'd0);
    chk("rst_ram_din", bus.RamDataIn, 32'd0);
    chk("rst_ram_size", {30'd0, bus.RamSize}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 18; i++) issue(tv[i]);
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      e.is_d = k != 4;
      e.data = k == 4 ? rd(8'h20, 2'b10) : rd(8'h10, 2'b10);
      e.err = 1'b0;
      sb.push_back(e);
    end
    bus.I_Req = 1'b1;
    bus.I_Address = 32'h20;
    bus.D_Req = 1'b1;
    bus.D_ReadWrite = 1'b0;
    bus.D_Size = 2'b10;
    bus.D_Address = 32'h10;
    grants = 0;
    i_at = 0;
    n = 0;
    while (grants < 6 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.I_Ready || bus.D_Ready) begin
        grants++;
        if (bus.I_Ready) begin
          i_at = grants;
          bus.I_Req = 1'b0;
        end
      end
    end
    bus.D_Req = 1'b0;
    bus.I_Req = 1'b0;
    chk("contention_grants", grants, 32'd6);
    chk("i_grant_index", i_at, 32'd5);
    @(posedge clk); #1;
    bus.D_Req = 1'b1;
    bus.D_ReadWrite = 1'b1;
    bus.D_Size = 2'b10;
    bus.D_Address = 32'h08;
    bus.D_DataIn = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    chk("midwr_access_rw", {31'd0, bus.RamReadWrite}, 32'd1);
    wr(8'h08, 2'b10, 32'hCAFEF00D);
    reset = 1'b0;
    @(negedge clk);
    chk("midwr_rw_cut", {31'd0, bus.RamReadWrite}, 32'd0);
    chk("midwr_no_ready", {31'd0, bus.D_Ready}, 32'd0);
    bus.D_Req = 1'b0;
    @(negedge clk);
    chk("midwr_still_idle", {31'd0, bus.D_Ready}, 32'd0);
    reset = 1'b1;
    issue(tv[0]);
    issue(tv[13]);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, want completion");
    $fatal(1);
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single data_ram256x8 byte-addressed RAM between two requesters:
  - the instruction-fetch port (I, read-only, word).
  - the data/MEM-stage port (D, read/write, byte/half-word/word).
- Sequences each RAM access as a registered, one-cycle drive of the RAM's ReadWrite/Address/DataIn/Size pins.
- Captures DataOut and returns it through a Req/Ready handshake.
- Sits between the pipeline's IF and MEM stages and the RAM instance.

Parameters:
- ADDR_BITS, 8: implemented RAM address width; addresses at or above 2^ADDR_BITS are out of range.
- MAX_D_STREAK, 4: maximum consecutive D grants while I_Req is pending before I is forced a grant.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- I_Req  in  1  fetch request; held with I_Address until I_Ready.
- I_Address  in  32  fetch byte address (word access).
- I_Ready  out  1  one-cycle pulse: I_DataOut valid.
- I_DataOut  out  32  fetched word, registered.
- D_Req  in  1  data request; held with all D_* inputs until D_Ready.
- D_ReadWrite  in  1  0 = read, 1 = write.
- D_Size  in  2  00 = byte, 01 = half-word, 10 = word, 11 = reserved.
- D_Address  in  32  data byte address.
- D_DataIn  in  32  write data, right-justified.
- D_Ready  out  1  one-cycle pulse: access complete, D_DataOut valid on reads.
- D_DataOut  out  32  read data, registered; 0 after writes.
- D_Err  out  1  valid with D_Ready; access was rejected.
- RamReadWrite  out  1  to RAM ReadWrite; registered.
- RamAddress  out  32  to RAM Address; registered.
- RamDataIn  out  32  to RAM DataIn; registered.
- RamSize  out  2  to RAM Size; registered.
- RamDataOut  in  32  from RAM DataOut (combinational read).

Behaviour:
- Reset (reset == 0 at a rising edge):
  - State goes to IDLE and the streak counter to 0.
  - All outputs go to 0; RamReadWrite = 0, so no write can occur.
- Reset mid-transaction:
  - The transaction is dropped; no Ready is issued.
  - A write in progress is cut off at that edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request pending: stay in IDLE; Ram* hold their last values with RamReadWrite = 0.
  - Request pending: arbitrate, register the winner's fields into Ram*, set owner, go to ACCESS.
- ACCESS (exactly one cycle):
  - The RAM sees the stable registered fields.
  - At the closing edge: capture RamDataOut into the owner's DataOut register, force RamReadWrite to 0, go to RESP.
- RESP (one cycle):
  - The owner's Ready is 1; D_Err is valid if the owner is D.
  - Req inputs are ignored; the requester deasserts Req or presents a new request in this cycle.
  - Go to IDLE.
- Latency and throughput:
  - Req high in IDLE at edge k gives Ready during cycle k+2.
  - Minimum of 3 cycles per access.
- Arbitration (fixed D priority with anti-starvation):
  - D wins if D_Req and not (I_Req and streak == MAX_D_STREAK); otherwise I wins.
  - streak increments on a D grant while I_Req = 1, saturating at MAX_D_STREAK.
  - streak clears on any I grant, or on a D grant with I_Req = 0.
- Simultaneous I_Req and D_Req in IDLE: the priority rule above applies; the loser's request stays pending and is served in the next IDLE.
- I grant: RamSize = 10, RamReadWrite = 0, RamAddress = I_Address.
- D grant: fields are copied directly; reserved size 11 is forwarded as 10.
- Read data: D_DataOut and I_DataOut are zero-extended per the RAM's size behaviour. The non-owner's DataOut register holds its value.
- Ready pulses are never simultaneous.

Optional Feature:
- Macro: ARB_ALIGN_CHECK_EN.
- Defined:
  - A D access is rejected if it is misaligned (half-word with addr[0] = 1; word with addr[1:0] != 0), has Size 11, or has address >= 2^ADDR_BITS.
  - A rejected access still passes through ACCESS, but with RamReadWrite = 0.
  - Response: D_Ready with D_Err = 1 and D_DataOut = 0.
  - I accesses are unchecked.
- Undefined: D_Err is tied to 0 and all accesses are forwarded unmodified.

Decomposition:
- Package ram_arb_pkg:
  - Size codes SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10.
  - State encoding (IDLE/ACCESS/RESP).
  - Owner encoding (OWN_I/OWN_D).
- Sub-module ram_arb_align_chk: combinational (Size, Address) -> err. It is instantiated only under ARB_ALIGN_CHECK_EN.

Test Plan:
- Reset / I read:
  - Stimulus: precharge RAM bytes 0..3 = 0x11,0x22,0x33,0x44 (RAM byte order); hold reset = 0 for 2 cycles; then I_Req, I_Address = 0.
  - Response: all outputs are 0 during reset; I_Ready is high exactly 2 cycles after the request is sampled; I_DataOut = the word at address 0 (0x11223344 if big-endian).
- D byte write then word read:
  - Stimulus: D write, Size 00, address 0, data 0xB5; then D word read at 0.
  - Response: RamReadWrite is high for exactly one cycle; the read returns 0xB5 in the top byte and the other bytes are unchanged.
- Contention:
  - Stimulus: hold I_Req and D_Req high continuously, with D re-requesting in each RESP.
  - Response: grant order D, D, D, D, I, D, ...; I_Ready is never delayed beyond MAX_D_STREAK + 1 accesses.
- Reset mid-write:
  - Stimulus: assert reset during an ACCESS cycle of a D word write to address 8.
  - Response: no D_Ready is issued; RamReadWrite = 0 from the next edge.
- Error path (ARB_ALIGN_CHECK_EN defined):
  - Stimulus: D word write at address 6, then a half-word read at address 0x100.
  - Response: both complete with D_Err = 1 and D_DataOut = 0; RAM contents are unchanged.
  - Without the macro, the same stimulus gives D_Err = 0.
- Back-to-back I fetches:
  - Stimulus: I fetches at addresses 0, 4, 8, 12.
  - Response: 4 I_Ready pulses spaced 3 cycles apart, with the correct words.
